// File: rtl/line_draw_ctrl_pkg.sv
// Shared types and default sizing for the line-engine request controller.
package line_ctrl_pkg;

  // Controller sequence: grant in IDLE, launch in START, engine runs in WAIT,
  // report in RESP.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int NUM_REQ_DEF = 4;
  localparam int COORD_W_DEF = 8;
  localparam int TIMEOUT_DEF = 4096;

endpackage

// File: rtl/line_draw_ctrl_if.sv
// Requester-side bundle: per-requester request and endpoints in, one-hot
// ack/err pulses and the currently served index out.
interface line_draw_ctrl_if
  import line_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int COORD_W = COORD_W_DEF
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*COORD_W-1:0] req_x0;
  logic [NUM_REQ*COORD_W-1:0] req_y0;
  logic [NUM_REQ*COORD_W-1:0] req_x1;
  logic [NUM_REQ*COORD_W-1:0] req_y1;
  logic [NUM_REQ-1:0]         ack;
  logic [NUM_REQ-1:0]         err;
  logic [IDX_W-1:0]           grant_id;
  logic                       busy;

  // Requester front-ends drive requests and endpoints.
  modport master (
    output req, req_x0, req_y0, req_x1, req_y1,
    input  ack, err, grant_id, busy
  );

  // The controller consumes requests and reports completion.
  modport slave (
    input  req, req_x0, req_y0, req_x1, req_y1,
    output ack, err, grant_id, busy
  );

endinterface

// File: rtl/line_draw_ctrl_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Kept generic so other shared ports can reuse it.
module rr_arbiter
  import line_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  localparam int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  localparam logic [IDX_W:0] NUM_REQ_V = (IDX_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [IDX_W-1:0]   off;
  logic [IDX_W:0]     sum;

  // Rotate so ptr sits at bit 0, take the lowest set bit, rotate the index back.
  always_comb begin
    rot = NUM_REQ'({req, req} >> ptr);
    off = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= NUM_REQ_V) sum = sum - NUM_REQ_V;
    gnt_idx = sum[IDX_W-1:0];
    gnt_vld = |req;
  end

endmodule

// File: rtl/line_draw_ctrl.sv
// Shares one Bresenham line engine among NUM_REQ requesters: round-robin
// grant, endpoint capture, one-cycle launch, watchdog-guarded wait, and a
// one-cycle ack (or err) back to the served requester.
module line_draw_ctrl
  import line_ctrl_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int COORD_W = COORD_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               n_rst,
  line_draw_ctrl_if.slave    bus,
  output logic [COORD_W-1:0] eng_x0,
  output logic [COORD_W-1:0] eng_y0,
  output logic [COORD_W-1:0] eng_x1,
  output logic [COORD_W-1:0] eng_y1,
  output logic               eng_start,
  input  logic               eng_done
);

  localparam int IDX_W = $clog2(NUM_REQ);
  // One spare bit so the saturating count can never alias TIMEOUT-1.
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_REQ - 1);

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grant_q;
  logic [CNT_W-1:0]   wd_cnt;
  logic [NUM_REQ-1:0] ack_q;
  logic [NUM_REQ-1:0] err_q;
  logic               busy_q;

  logic [IDX_W-1:0]   arb_idx;
  logic               arb_vld;

  // Watchdog increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Successor index modulo NUM_REQ (NUM_REQ need not be a power of two).
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_LAST) ? '0 : i + IDX_W'(1);
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    return NUM_REQ'(1) << i;
  endfunction

  // Extract requester i's coordinate slice from a packed per-requester bus.
  function automatic logic [COORD_W-1:0] pick(
    input logic [NUM_REQ*COORD_W-1:0] v,
    input logic [IDX_W-1:0]           i
  );
    logic [COORD_W-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (i == IDX_W'(k)) r = v[k*COORD_W +: COORD_W];
    end
    return r;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req     (bus.req),
    .ptr     (ptr),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  // Controller FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      ptr       <= '0;
      grant_q   <= '0;
      wd_cnt    <= '0;
      eng_x0    <= '0;
      eng_y0    <= '0;
      eng_x1    <= '0;
      eng_y1    <= '0;
      eng_start <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      case (state)
        IDLE: begin
          // Endpoints are captured only here; later changes by the requester
          // do not disturb the line in flight.
          if (arb_vld) begin
            grant_q   <= arb_idx;
            eng_x0    <= pick(bus.req_x0, arb_idx);
            eng_y0    <= pick(bus.req_y0, arb_idx);
            eng_x1    <= pick(bus.req_x1, arb_idx);
            eng_y1    <= pick(bus.req_y1, arb_idx);
            eng_start <= 1'b1;
            busy_q    <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          wd_cnt <= '0;
          ptr    <= next_idx(grant_q);
          state  <= WAIT;
        end
        WAIT: begin
          wd_cnt <= sat_inc(wd_cnt);
          // Completion wins over a watchdog expiry in the same cycle.
          if (eng_done) begin
            ack_q <= onehot(grant_q);
            state <= RESP;
          end else if (wd_cnt == CNT_LAST) begin
            err_q <= onehot(grant_q);
            state <= RESP;
          end
        end
        RESP: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_line_draw_ctrl.sv
// Directed bench for line_draw_ctrl: two instances share the clock and reset,
// one with a long watchdog for normal traffic and one with TIMEOUT=16 for
// watchdog behaviour.
module tb_line_draw_ctrl;

  logic clk;
  logic n_rst;

  logic [7:0] eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a;
  logic       eng_start_a, eng_done_a;
  logic [7:0] eng_x0_b, eng_y0_b, eng_x1_b, eng_y1_b;
  logic       eng_start_b, eng_done_b;

  int n_cmp;
  int n_bad;

  line_draw_ctrl_if #(.NUM_REQ(4), .COORD_W(8)) ifa ();
  line_draw_ctrl_if #(.NUM_REQ(4), .COORD_W(8)) ifb ();

  line_draw_ctrl #(.NUM_REQ(4), .COORD_W(8), .TIMEOUT(64)) u_a (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (ifa),
    .eng_x0    (eng_x0_a),
    .eng_y0    (eng_y0_a),
    .eng_x1    (eng_x1_a),
    .eng_y1    (eng_y1_a),
    .eng_start (eng_start_a),
    .eng_done  (eng_done_a)
  );

  line_draw_ctrl #(.NUM_REQ(4), .COORD_W(8), .TIMEOUT(16)) u_b (
    .clk       (clk),
    .n_rst     (n_rst),
    .bus       (ifb),
    .eng_x0    (eng_x0_b),
    .eng_y0    (eng_y0_b),
    .eng_x1    (eng_x1_b),
    .eng_y1    (eng_y1_b),
    .eng_start (eng_start_b),
    .eng_done  (eng_done_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // c packs {x0, y0, x1, y1}
  task automatic set_a(input int i, input logic [31:0] c);
    ifa.req_x0[i*8 +: 8] = c[31:24];
    ifa.req_y0[i*8 +: 8] = c[23:16];
    ifa.req_x1[i*8 +: 8] = c[15:8];
    ifa.req_y1[i*8 +: 8] = c[7:0];
  endtask

  task automatic set_b(input int i, input logic [31:0] c);
    ifb.req_x0[i*8 +: 8] = c[31:24];
    ifb.req_y0[i*8 +: 8] = c[23:16];
    ifb.req_x1[i*8 +: 8] = c[15:8];
    ifb.req_y1[i*8 +: 8] = c[7:0];
  endtask

  // Called in an IDLE cycle with the request already driven. Engine done is
  // raised dly cycles after the START cycle. rearm >= 0 re-raises that
  // requester's req during START (it dropped it on its own ack edge).
  task automatic serve_a(input int id, input logic [31:0] exp_c, input int dly,
                         input int rearm, input string tag);
    int extra;
    extra = 0;
    tick();
    chk({tag, "_start"}, 32'(eng_start_a), 32'd1);
    chk({tag, "_gid"}, 32'(ifa.grant_id), 32'(id));
    chk({tag, "_coord"}, {eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a}, exp_c);
    chk({tag, "_busy"}, 32'(ifa.busy), 32'd1);
    if (rearm >= 0) ifa.req[rearm] = 1'b1;
    for (int i = 1; i <= dly; i++) begin
      tick();
      if (eng_start_a) extra++;
    end
    chk({tag, "_extra_start"}, 32'(extra), 32'd0);
    eng_done_a = 1'b1;
    tick();
    chk({tag, "_ack"}, 32'(ifa.ack), 32'd1 << id);
    chk({tag, "_err"}, 32'(ifa.err), 32'd0);
    ifa.req[id] = 1'b0;
    eng_done_a  = 1'b0;
    tick();
    chk({tag, "_ack_lo"}, 32'(ifa.ack), 32'd0);
    chk({tag, "_busy_lo"}, 32'(ifa.busy), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    n_rst = 1'b0;
    ifa.req = '0; ifa.req_x0 = '0; ifa.req_y0 = '0; ifa.req_x1 = '0; ifa.req_y1 = '0;
    ifb.req = '0; ifb.req_x0 = '0; ifb.req_y0 = '0; ifb.req_x1 = '0; ifb.req_y1 = '0;
    eng_done_a = 1'b0;
    eng_done_b = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_busy", 32'(ifa.busy), 32'd0);
    chk("rst_ackerr", {24'd0, ifa.ack, ifa.err}, 32'd0);
    chk("rst_gid_start", {29'd0, ifa.grant_id, eng_start_a}, 32'd0);
    chk("rst_coord", {eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a}, 32'd0);
    chk("rst_b_busy", 32'(ifb.busy), 32'd0);
    n_rst = 1'b1;
    tick();

    // Single requester 0: (16,16)->(64,64), done 49 cycles after start
    set_a(0, 32'h10104040);
    ifa.req = 4'b0001;
    serve_a(0, 32'h10104040, 49, -1, "single");
    chk("single_hold", {eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a}, 32'h10104040);

    // Reset asserted in WAIT (ptr is 1 before this grant, 3 after it)
    set_a(2, 32'h55667788);
    ifa.req = 4'b0100;
    tick();
    chk("rw_gid", 32'(ifa.grant_id), 32'd2);
    tick();
    tick();
    #2;
    n_rst = 1'b0;
    #1;
    chk("rw_async_ctl", {26'd0, ifa.busy, eng_start_a, ifa.grant_id, 2'b00}, 32'd0);
    chk("rw_async_pulse", {24'd0, ifa.ack, ifa.err}, 32'd0);
    chk("rw_async_coord", {eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a}, 32'd0);
    ifa.req = '0;
    tick();
    n_rst = 1'b1;
    tick();
    // ptr back at 0: requesters 0 and 3 both pending -> 0 wins
    set_a(0, 32'h01020304);
    set_a(3, 32'h30303030);
    ifa.req = 4'b1001;
    serve_a(0, 32'h01020304, 2, -1, "rw_ptr");
    // requester 3 alone; degenerate line issued normally
    serve_a(3, 32'h30303030, 3, -1, "rw_r3");

    // Round robin with all four requesting, minimum turnaround
    set_a(1, 32'h11121314);
    set_a(2, 32'h21222324);
    ifa.req = 4'b1111;
    serve_a(0, 32'h01020304, 1, -1, "rr0");
    serve_a(1, 32'h11121314, 1, 0, "rr1");
    serve_a(2, 32'h21222324, 1, 1, "rr2");
    serve_a(3, 32'h30303030, 1, 2, "rr3");
    serve_a(0, 32'h01020304, 1, 3, "rr4");
    ifa.req = '0;

    // Late arrival of requester 2 while requester 1 is in WAIT
    set_a(1, 32'hA0A1A2A3);
    ifa.req = 4'b0010;
    tick();
    chk("late_gid1", 32'(ifa.grant_id), 32'd1);
    tick();
    set_a(2, 32'hB0B1B2B3);
    ifa.req[2] = 1'b1;
    tick();
    tick();
    chk("late_nolatch", {eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a}, 32'hA0A1A2A3);
    eng_done_a = 1'b1;
    tick();
    chk("late_ack1", 32'(ifa.ack), 32'h2);
    ifa.req[1] = 1'b0;
    eng_done_a = 1'b0;
    tick();
    chk("late_idle_gid", 32'(ifa.grant_id), 32'd1);
    chk("late_idle_hold", {eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a}, 32'hA0A1A2A3);
    tick();
    chk("late_start2", 32'(eng_start_a), 32'd1);
    chk("late_gid2", 32'(ifa.grant_id), 32'd2);
    chk("late_coord2", {eng_x0_a, eng_y0_a, eng_x1_a, eng_y1_a}, 32'hB0B1B2B3);
    tick();
    eng_done_a = 1'b1;
    tick();
    chk("late_ack2", 32'(ifa.ack), 32'h4);
    ifa.req[2] = 1'b0;
    eng_done_a = 1'b0;
    tick();

    // Watchdog, TIMEOUT=16: engine never finishes
    set_b(1, 32'h01020304);
    ifb.req = 4'b0010;
    tick();
    chk("to_start", 32'(eng_start_b), 32'd1);
    chk("to_gid", 32'(ifb.grant_id), 32'd1);
    chk("to_coord", {eng_x0_b, eng_y0_b, eng_x1_b, eng_y1_b}, 32'h01020304);
    repeat (16) tick();
    chk("to_pre_err", {24'd0, ifb.ack, ifb.err}, 32'd0);
    chk("to_pre_busy", 32'(ifb.busy), 32'd1);
    tick();
    chk("to_err", 32'(ifb.err), 32'h2);
    chk("to_noack", 32'(ifb.ack), 32'd0);
    ifb.req = '0;
    tick();
    chk("to_err_lo", 32'(ifb.err), 32'd0);
    chk("to_busy_lo", 32'(ifb.busy), 32'd0);

    // Next request relaunches; done coincides with the last watchdog count
    set_b(2, 32'h0A0B0C0D);
    ifb.req = 4'b0100;
    tick();
    chk("co_start", 32'(eng_start_b), 32'd1);
    chk("co_gid", 32'(ifb.grant_id), 32'd2);
    chk("co_coord", {eng_x0_b, eng_y0_b, eng_x1_b, eng_y1_b}, 32'h0A0B0C0D);
    repeat (16) tick();
    eng_done_b = 1'b1;
    tick();
    chk("co_ack", 32'(ifb.ack), 32'h4);
    chk("co_noerr", 32'(ifb.err), 32'd0);
    ifb.req = '0;
    eng_done_b = 1'b0;
    tick();
    chk("co_ack_lo", 32'(ifb.ack), 32'd0);
    chk("co_busy_lo", 32'(ifb.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
